// File: rtl/jenc_rx_buffer.sv
// Ping-pong receive buffer: collects UART bytes into packets closed by line idle,
// then bursts each accepted packet out contiguously while the next one is received.
module jenc_rx_buffer #(
    parameter int unsigned MAX_LEN     = 64,
    parameter int unsigned MIN_LEN     = 36,
    parameter int unsigned IDLE_CYCLES = 200
) (
    input  logic        c,
    input  logic        rst_n,
    input  logic [7:0]  in_d,
    input  logic        in_dv,
    output logic [7:0]  rxd,
    output logic        rxdv,
    output logic [6:0]  pkt_len,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W  = $clog2(MAX_LEN);
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {R_IDLE, R_RECV, R_DROP} rx_state_e;
    typedef enum logic [1:0] {D_IDLE, D_READ, D_BURST} dr_state_e;

    logic [7:0] mem [2][MAX_LEN];

    rx_state_e         rx_state_q, rx_state_d;
    dr_state_e         dr_state_q, dr_state_d;
    logic [LEN_W-1:0]  wr_len_q, wr_len_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              wr_bank_q, wr_bank_d;
    logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [7:0]        rxd_q, rxd_d;
    logic              rxdv_q, rxdv_d;
    logic              busy_q, busy_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;

    logic              wr_en_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic              swap_c;
    logic              err_inc_c;
    logic              idle_hit_c;
    logic              burst_active_c;
    logic [7:0]        rd_byte_c;

    assign idle_hit_c     = !in_dv && ((idle_q + IDLE_W'(1)) == IDLE_W'(IDLE_CYCLES));
    assign burst_active_c = (dr_state_q != D_IDLE);
    assign rd_byte_c      = mem[~wr_bank_q][IDX_W'(rd_idx_q)];

    // Receive FSM, packet close decision and counters
    always_comb begin
        rx_state_d = rx_state_q;
        wr_len_d   = wr_len_q;
        idle_d     = idle_q;
        wr_bank_d  = wr_bank_q;
        pkt_len_d  = pkt_len_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        wr_en_c    = 1'b0;
        wr_idx_c   = IDX_W'(wr_len_q);
        swap_c     = 1'b0;
        err_inc_c  = 1'b0;

        case (rx_state_q)
            R_IDLE: begin
                idle_d = '0;
                if (in_dv) begin
                    wr_en_c    = 1'b1;
                    wr_idx_c   = '0;
                    wr_len_d   = LEN_W'(1);
                    rx_state_d = R_RECV;
                end
            end
            R_RECV: begin
                if (in_dv) begin
                    idle_d = '0;
                    if (wr_len_q == LEN_W'(MAX_LEN)) begin
                        rx_state_d = R_DROP;
                    end else begin
                        wr_en_c  = 1'b1;
                        wr_len_d = wr_len_q + LEN_W'(1);
                    end
                end else if (idle_hit_c) begin
                    rx_state_d = R_IDLE;
                    idle_d     = '0;
                    wr_len_d   = '0;
                    if (wr_len_q < LEN_W'(MIN_LEN) || burst_active_c) begin
                        err_inc_c = 1'b1;
                    end else begin
                        swap_c = 1'b1;
                    end
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            R_DROP: begin
                if (in_dv) begin
                    idle_d = '0;
                end else if (idle_hit_c) begin
                    rx_state_d = R_IDLE;
                    idle_d     = '0;
                    wr_len_d   = '0;
                    err_inc_c  = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase

        if (swap_c) begin
            wr_bank_d = ~wr_bank_q;
            pkt_len_d = wr_len_q;
            pkt_cnt_d = (pkt_cnt_q == CNT_MAX) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
        end
        if (err_inc_c) begin
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 16'd1;
        end
    end

    // Drain FSM: one cycle to fetch byte 0, then one byte per cycle
    always_comb begin
        dr_state_d = dr_state_q;
        rd_idx_d   = rd_idx_q;
        rxd_d      = rxd_q;
        rxdv_d     = 1'b0;
        busy_d     = busy_q;

        case (dr_state_q)
            D_IDLE: begin
                if (swap_c) begin
                    dr_state_d = D_READ;
                    rd_idx_d   = '0;
                    busy_d     = 1'b1;
                end
            end
            D_READ: begin
                rxd_d      = rd_byte_c;
                rxdv_d     = 1'b1;
                rd_idx_d   = rd_idx_q + LEN_W'(1);
                dr_state_d = D_BURST;
            end
            D_BURST: begin
                if (rd_idx_q == pkt_len_q) begin
                    busy_d     = 1'b0;
                    dr_state_d = D_IDLE;
                end else begin
                    rxd_d    = rd_byte_c;
                    rxdv_d   = 1'b1;
                    rd_idx_d = rd_idx_q + LEN_W'(1);
                end
            end
            default: dr_state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            dr_state_q <= D_IDLE;
            wr_len_q   <= '0;
            idle_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            pkt_len_q  <= '0;
            rxd_q      <= 8'h00;
            rxdv_q     <= 1'b0;
            busy_q     <= 1'b0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            dr_state_q <= dr_state_d;
            wr_len_q   <= wr_len_d;
            idle_q     <= idle_d;
            wr_bank_q  <= wr_bank_d;
            rd_idx_q   <= rd_idx_d;
            pkt_len_q  <= pkt_len_d;
            rxd_q      <= rxd_d;
            rxdv_q     <= rxdv_d;
            busy_q     <= busy_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Packet storage is not reset; contents are only read after being written
    always_ff @(posedge c) begin
        if (wr_en_c) begin
            mem[wr_bank_q][wr_idx_c] <= in_d;
        end
    end

    assign rxd     = rxd_q;
    assign rxdv    = rxdv_q;
    assign pkt_len = 7'(pkt_len_q);
    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
    assign busy    = busy_q;

endmodule
